// File: rtl/bsg_miniblade_tile_reset_sequencer.sv
// Purpose : staggered per-tile reset release for a column, plus registered column coordinates.
// Latency : coordinates 1 cycle; tile i released min_assert_p+1+i*(gap_p+1) edges after ASSERT entry.
// Backpres: none; core_reset_i may abort the sequence at any time. Option: BSG_MINIBLADE_RESET_SEQ_EVENT_CNT_EN.
module bsg_miniblade_tile_reset_sequencer #(
   parameter int x_cord_width_p = 4,
   parameter int y_cord_width_p = 4,
   parameter int num_tiles_p    = 4,
   parameter int min_assert_p   = 16,
   parameter int gap_p          = 8
) (
   input  logic                                  clk_i,
   input  logic                                  reset_n_i,
   input  logic                                  core_reset_i,
   input  logic [x_cord_width_p-1:0]             global_x_i,
   input  logic [y_cord_width_p-1:0]             global_y_i,
   output logic [num_tiles_p-1:0]                tile_reset_o,
   output logic                                  done_o,
   output logic [x_cord_width_p-1:0]             global_x_o,
   output logic [num_tiles_p*y_cord_width_p-1:0] global_y_o
`ifdef BSG_MINIBLADE_RESET_SEQ_EVENT_CNT_EN
  ,output logic [15:0]                           reset_event_count_o
`endif
);

   // Counter must hold up to the larger of the two windows.
   localparam int cnt_max     = (min_assert_p > gap_p) ? min_assert_p : gap_p;
   localparam int cnt_width   = $clog2(cnt_max + 1);
   localparam int idx_width   = (num_tiles_p > 1) ? $clog2(num_tiles_p) : 1;
   localparam logic [cnt_width-1:0] assert_last = cnt_width'(min_assert_p - 1);
   localparam logic [cnt_width-1:0] gap_last    = cnt_width'(gap_p - 1);
   localparam logic [idx_width-1:0] idx_last    = idx_width'(num_tiles_p - 1);

   typedef enum logic [1:0] {ASSERT, RELEASE, GAP, DONE} state_t;

   state_t                     state_r, state_n;
   logic [cnt_width-1:0]       cnt_r, cnt_n;
   logic [idx_width-1:0]       idx_r, idx_n;
   logic [num_tiles_p-1:0]     tile_reset_r, tile_reset_n;
   logic                       done_r, done_n;
   logic                       core_reset_r;
   logic [x_cord_width_p-1:0]  x_r;
   logic [y_cord_width_p-1:0]  y_r;

   // Input staging: reset request and coordinates each take one register.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         core_reset_r <= 1'b0;
         x_r          <= '0;
         y_r          <= '0;
      end else begin
         core_reset_r <= core_reset_i;
         x_r          <= global_x_i;
         y_r          <= global_y_i;
      end
   end

   // Sequencer state register; outputs are registered here too.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_r      <= ASSERT;
         cnt_r        <= '0;
         idx_r        <= '0;
         tile_reset_r <= '1;
         done_r       <= 1'b0;
      end else begin
         state_r      <= state_n;
         cnt_r        <= cnt_n;
         idx_r        <= idx_n;
         tile_reset_r <= tile_reset_n;
         done_r       <= done_n;
      end
   end

   // Next-state logic; a reset request outside ASSERT wins over any pending release.
   always_comb begin
      state_n      = state_r;
      cnt_n        = cnt_r;
      idx_n        = idx_r;
      tile_reset_n = tile_reset_r;
      done_n       = done_r;
      if (core_reset_r && (state_r != ASSERT)) begin
         state_n      = ASSERT;
         cnt_n        = '0;
         idx_n        = '0;
         tile_reset_n = '1;
         done_n       = 1'b0;
      end else begin
         case (state_r)
            ASSERT: begin
               tile_reset_n = '1;
               done_n       = 1'b0;
               // Keeps counting during a request so a short pulse does not restart the window.
               if (cnt_r != assert_last) cnt_n = cnt_r + cnt_width'(1);
               if ((cnt_r == assert_last) && !core_reset_r) state_n = RELEASE;
            end
            RELEASE: begin
               for (int i = 0; i < num_tiles_p; i++) begin
                  if (idx_r == idx_width'(i)) tile_reset_n[i] = 1'b0;
               end
               if (idx_r == idx_last) begin
                  state_n = DONE;
                  done_n  = 1'b1;
               end else begin
                  idx_n   = idx_r + idx_width'(1);
                  cnt_n   = '0;
                  state_n = GAP;
               end
            end
            GAP: begin
               if (cnt_r == gap_last) state_n = RELEASE;
               else                   cnt_n   = cnt_r + cnt_width'(1);
            end
            DONE: begin
               tile_reset_n = '0;
               done_n       = 1'b1;
            end
            default: state_n = ASSERT;
         endcase
      end
   end

   assign tile_reset_o = tile_reset_r;
   assign done_o       = done_r;
   assign global_x_o   = x_r;

   // Tile i sits i+1 rows above the base coordinate; the sum wraps at the field width.
   for (genvar i = 0; i < num_tiles_p; i++) begin : g_y
      assign global_y_o[i*y_cord_width_p +: y_cord_width_p] = y_r + y_cord_width_p'(i + 1);
   end

`ifdef BSG_MINIBLADE_RESET_SEQ_EVENT_CNT_EN
   logic [15:0] event_cnt_r;

   // Count rising edges of the staged reset request, saturating.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         event_cnt_r <= '0;
      end else if (core_reset_i && !core_reset_r && (event_cnt_r != 16'hFFFF)) begin
         event_cnt_r <= event_cnt_r + 16'd1;
      end
   end

   assign reset_event_count_o = event_cnt_r;
`endif

endmodule
